force_cache_rx: RTL

//  Egress end of the ring: one instance per cell, fed by that cell's ring node output (data_valid/data_out).

---
 rtl/force_cache_rx_pkg.sv | 68 ++++++
 rtl/force_cache_bank.sv | 39 +++
 rtl/force_cache_rx.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/force_cache_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : force_cache_rx_pkg
//  Description : Shared types and constants for the force-cache receive block.
//                Holds the ring beat type, the packed cache entry type, the
//                FSM state encoding and per-component add helpers (wrapping,
//                overflow detect, saturating).
//                The saturating helper is used when FORCE_CACHE_SAT_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package force_cache_rx_pkg;

    localparam int DATA_WIDTH        = 32;
    localparam int PARTICLE_ID_WIDTH = 7;
    localparam int FORCE_CACHE_WIDTH = 3 * DATA_WIDTH;
    localparam int FC_DEPTH          = 1 << PARTICLE_ID_WIDTH;

    // One ring beat: target particle plus its partial force
    typedef struct packed {
        logic [PARTICLE_ID_WIDTH-1:0] particle_id;
        logic [DATA_WIDTH-1:0]        fz;
        logic [DATA_WIDTH-1:0]        fy;
        logic [DATA_WIDTH-1:0]        fx;
    } force_data_t;

    // One cache entry, packed {fz,fy,fx}
    typedef struct packed {
        logic [DATA_WIDTH-1:0] fz;
        logic [DATA_WIDTH-1:0] fy;
        logic [DATA_WIDTH-1:0] fx;
    } fc_entry_t;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } fc_state_t;

    function automatic logic [DATA_WIDTH-1:0] fc_add_wrap(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        return a + b;
    endfunction

    // Signed overflow: operands share a sign and the sum does not
    function automatic logic fc_add_ovf(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH-1:0] s;
        s = a + b;
        return (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (s[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] fc_add_sat(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        if (fc_add_ovf(a, b)) begin
            return a[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                   : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
        return a + b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/force_cache_bank.sv
`default_nettype none
// ============================================================================
//  Module      : force_cache_bank
//  Description : Simple dual-port RAM, FC_DEPTH x FORCE_CACHE_WIDTH.
//                One write port, one read port, registered read data
//                (1-cycle latency), read-first on a same-address collision.
//  Ports       : clk      - clock
//                i_we     - write enable
//                i_waddr  - write address
//                i_wdata  - write data
//                i_raddr  - read address
//                o_rdata  - read data, valid the cycle after i_raddr
//  Revision    : 1.0 - initial release
// ============================================================================
module force_cache_bank
    import force_cache_rx_pkg::*;
(
    input  logic                         clk,
    input  logic                         i_we,
    input  logic [PARTICLE_ID_WIDTH-1:0] i_waddr,
    input  fc_entry_t                    i_wdata,
    input  logic [PARTICLE_ID_WIDTH-1:0] i_raddr,
    output fc_entry_t                    o_rdata
);

    fc_entry_t r_mem [FC_DEPTH];
    fc_entry_t r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/force_cache_rx.sv
`default_nettype none
// ============================================================================
//  Module      : force_cache_rx
//  Description : Ring egress force cache. Accumulates partial forces per
//                home-cell particle in a two-stage read-modify-write pipe and
//                serves a clear-on-read readout port. After reset a CLEAR
//                sweep zeroes every entry before accumulation starts.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                in_valid, in_data   - ring beat (no backpressure)
//                rd_req, rd_pid      - readout request / particle
//                rd_ready            - request accepted when rd_req & rd_ready
//                rd_valid, rd_force  - readout data (2 cycles after accept)
//                busy                - sweep or accumulation in flight
//                drop_err            - sticky: beat dropped during sweep
//                sat_flag            - sticky saturation (FORCE_CACHE_SAT_EN)
//  Config      : define FORCE_CACHE_SAT_EN for saturating adds + sat_flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module force_cache_rx
    import force_cache_rx_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  force_data_t                  in_data,
    input  logic                         rd_req,
    input  logic [PARTICLE_ID_WIDTH-1:0] rd_pid,
    output logic                         rd_ready,
    output logic                         rd_valid,
    output logic [FORCE_CACHE_WIDTH-1:0] rd_force,
    output logic                         busy,
    output logic                         drop_err
`ifdef FORCE_CACHE_SAT_EN
    ,
    output logic                         sat_flag
`endif
);

    localparam logic [PARTICLE_ID_WIDTH-1:0] c_LAST = PARTICLE_ID_WIDTH'(FC_DEPTH - 1);

    fc_state_t                    r_state;
    logic [PARTICLE_ID_WIDTH-1:0] r_ctr;

    // Accumulate pipe
    logic                         r_s0_valid;
    logic [PARTICLE_ID_WIDTH-1:0] r_s0_pid;
    fc_entry_t                    r_s0_force;
    logic                         r_s1_valid;
    logic [PARTICLE_ID_WIDTH-1:0] r_s1_pid;
    fc_entry_t                    r_s1_force;
    logic                         r_s1_fwd;
    fc_entry_t                    r_s1_fwd_data;

    // Readout pipe
    logic                         r_rd1_valid;
    logic [PARTICLE_ID_WIDTH-1:0] r_rd1_pid;
    logic                         r_rd1_zero;
    logic                         r_rd_valid;
    fc_entry_t                    r_rd_force;
    logic                         r_drop_err;
`ifdef FORCE_CACHE_SAT_EN
    logic                         r_sat_flag;
    logic                         w_sat_hit;
`endif

    logic                         w_run;
    logic                         w_rd_accept;
    logic [PARTICLE_ID_WIDTH-1:0] w_raddr;
    fc_entry_t                    w_rdata;
    fc_entry_t                    w_operand;
    fc_entry_t                    w_sum;
    logic                         w_we;
    logic [PARTICLE_ID_WIDTH-1:0] w_waddr;
    fc_entry_t                    w_wdata;

    assign w_run       = (r_state == ST_RUN);
    assign rd_ready    = w_run & ~in_valid & ~r_s0_valid & ~r_s1_valid;
    assign w_rd_accept = rd_req & rd_ready;

    // S0 and an accepted read never coexist, so they share the read port.
    assign w_raddr = r_s0_valid ? r_s0_pid : rd_pid;

    // The RAM samples the S0 address one edge after S0 loads, so the only
    // write it can miss is the one S1 performs at that same edge. An older
    // write-back has already landed by then and needs no bypass.
    always_comb begin
        w_operand = r_s1_fwd ? r_s1_fwd_data : w_rdata;
`ifdef FORCE_CACHE_SAT_EN
        w_sum.fx  = fc_add_sat(w_operand.fx, r_s1_force.fx);
        w_sum.fy  = fc_add_sat(w_operand.fy, r_s1_force.fy);
        w_sum.fz  = fc_add_sat(w_operand.fz, r_s1_force.fz);
        w_sat_hit = fc_add_ovf(w_operand.fx, r_s1_force.fx)
                  | fc_add_ovf(w_operand.fy, r_s1_force.fy)
                  | fc_add_ovf(w_operand.fz, r_s1_force.fz);
`else
        w_sum.fx  = fc_add_wrap(w_operand.fx, r_s1_force.fx);
        w_sum.fy  = fc_add_wrap(w_operand.fy, r_s1_force.fy);
        w_sum.fz  = fc_add_wrap(w_operand.fz, r_s1_force.fz);
`endif
    end

    // Single write slot: sweep, accumulate write-back, or clear-on-read.
    // Accumulate and clear-on-read are mutually exclusive because a read is
    // only accepted with the accumulate pipe empty and no beat arriving.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_ctr;
        w_wdata = '0;
        if (r_state == ST_CLEAR) begin
            w_we = 1'b1;
        end else if (r_s1_valid) begin
            w_we    = 1'b1;
            w_waddr = r_s1_pid;
            w_wdata = w_sum;
        end else if (r_rd1_valid) begin
            w_we    = 1'b1;
            w_waddr = r_rd1_pid;
        end
    end

    force_cache_bank u_bank (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_CLEAR;
            r_ctr       <= '0;
            r_s0_valid  <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_fwd    <= 1'b0;
            r_rd1_valid <= 1'b0;
            r_rd1_zero  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_force  <= '0;
            r_drop_err  <= 1'b0;
`ifdef FORCE_CACHE_SAT_EN
            r_sat_flag  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_ctr <= r_ctr + PARTICLE_ID_WIDTH'(1);
                    if (r_ctr == c_LAST) begin
                        r_state <= ST_RUN;
                    end
                    if (in_valid) begin
                        r_drop_err <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase

            // S0: capture the beat, address goes to the RAM this cycle
            r_s0_valid <= w_run & in_valid;
            if (in_valid) begin
                r_s0_pid      <= in_data.particle_id;
                r_s0_force.fx <= in_data.fx;
                r_s0_force.fy <= in_data.fy;
                r_s0_force.fz <= in_data.fz;
            end

            // S1: add and write back; note whether the next S1 must bypass
            r_s1_valid <= r_s0_valid;
            if (r_s0_valid) begin
                r_s1_pid      <= r_s0_pid;
                r_s1_force    <= r_s0_force;
                r_s1_fwd      <= r_s1_valid && (r_s1_pid == r_s0_pid);
                r_s1_fwd_data <= w_sum;
            end

            // Readout: a re-read of the entry being cleared this cycle would
            // see pre-clear RAM data, so it is forced to zero instead.
            r_rd1_valid <= w_rd_accept;
            if (w_rd_accept) begin
                r_rd1_pid  <= rd_pid;
                r_rd1_zero <= r_rd1_valid && (r_rd1_pid == rd_pid);
            end
            r_rd_valid <= r_rd1_valid;
            if (r_rd1_valid) begin
                r_rd_force <= r_rd1_zero ? '0 : w_rdata;
            end

`ifdef FORCE_CACHE_SAT_EN
            if (r_s1_valid && w_sat_hit) begin
                r_sat_flag <= 1'b1;
            end
`endif
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_force = r_rd_force;
    assign busy     = (r_state == ST_CLEAR) | r_s0_valid | r_s1_valid;
    assign drop_err = r_drop_err;
`ifdef FORCE_CACHE_SAT_EN
    assign sat_flag = r_sat_flag;
`endif

endmodule
`default_nettype wire
